// File: rtl/sparse_pe_stream_if.sv
// Operand streams in and out of one sparse PE, plus its result port.
// Latency: none (wiring only); forwarded and result fields are registered inside the PE.
// Backpressure: none; valid-qualified streams that are always accepted.
interface sparse_pe_stream_if #(
   parameter int DATA_WIDTH = 8,
   parameter int INDEX_SIZE = 3
);
   logic [DATA_WIDTH-1:0] i_up;
   logic [DATA_WIDTH-1:0] i_left;
   logic [INDEX_SIZE-1:0] index_up;
   logic [INDEX_SIZE-1:0] index_left;
   logic                  valid_up;
   logic                  valid_left;
   logic                  last_up;
   logic                  last_left;
   logic [DATA_WIDTH-1:0] o_down;
   logic [DATA_WIDTH-1:0] o_right;
   logic [INDEX_SIZE-1:0] index_down;
   logic [INDEX_SIZE-1:0] index_right;
   logic                  valid_down;
   logic                  valid_right;
   logic                  last_down;
   logic                  last_right;
   logic [DATA_WIDTH-1:0] o_result;
   logic                  o_result_valid;
   logic                  o_sat;
   logic                  busy;

   modport slave (
      input  i_up, i_left, index_up, index_left, valid_up, valid_left, last_up, last_left,
      output o_down, o_right, index_down, index_right, valid_down, valid_right,
             last_down, last_right, o_result, o_result_valid, o_sat, busy
   );

   modport master (
      output i_up, i_left, index_up, index_left, valid_up, valid_left, last_up, last_left,
      input  o_down, o_right, index_down, index_right, valid_down, valid_right,
             last_down, last_right, o_result, o_result_valid, o_sat, busy
   );
endinterface

// File: rtl/sparse_pe_stream.sv
// Sparse dot-product PE: matches (index,value) streams from up/left, accumulates products per tile.
// Latency: forwarded operands 1 cycle; result strobe 1 cycle after the edge where both sides are done.
// Backpressure: none; every valid element is consumed or forwarded, done sides ignore further input.
module sparse_pe_stream #(
   parameter int DATA_WIDTH  = 8,
   parameter int FRAC_BITS   = 4,
   parameter int INDEX_SIZE  = 3,
   parameter int ACC_WIDTH   = 16,
   parameter int CACHE_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   sparse_pe_stream_if.slave  pe
);
   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 2;
   localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};
   localparam logic [SUM_W-1:0] RES_MAX = {{(SUM_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

   // Windows hold the most recent accepted elements; slot 0 is the newest.
   logic [CACHE_DEPTH-1:0][INDEX_SIZE-1:0] uwin_idx_q, lwin_idx_q;
   logic [CACHE_DEPTH-1:0][DATA_WIDTH-1:0] uwin_val_q, lwin_val_q;
   logic [CACHE_DEPTH-1:0]                 uwin_vld_q, lwin_vld_q;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                  acc_sat_q, acc_sat_d;
   logic                  done_up_q, done_up_d, done_left_q, done_left_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic                  res_vld_q, res_sat_q, res_sat_d;
   logic [DATA_WIDTH-1:0] fwd_dn_q, fwd_rt_q;
   logic [INDEX_SIZE-1:0] fwd_dn_idx_q, fwd_rt_idx_q;
   logic                  fwd_dn_vld_q, fwd_rt_vld_q, fwd_dn_last_q, fwd_rt_last_q;

   logic                  up_acc, left_acc, complete;
   logic [PROD_W-1:0]     p_direct, p_upwin, p_leftwin;
   logic [SUM_W-1:0]      sum, acc_ext;

   function automatic logic [PROD_W-1:0] fx_mul(input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
      logic [PROD_W-1:0] full;
      full = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
      return full >> FRAC_BITS;
   endfunction

   // Match the new elements against each other and against the other side's pre-shift window.
   always_comb begin
      up_acc    = pe.valid_up & ~done_up_q;
      left_acc  = pe.valid_left & ~done_left_q;
      p_direct  = '0;
      p_upwin   = '0;
      p_leftwin = '0;
      if (up_acc && left_acc && (pe.index_up == pe.index_left))
         p_direct = fx_mul(pe.i_up, pe.i_left);
      for (int k = 0; k < CACHE_DEPTH; k++) begin
         if (up_acc && lwin_vld_q[k] && (lwin_idx_q[k] == pe.index_up))
            p_upwin = fx_mul(pe.i_up, lwin_val_q[k]);
         if (left_acc && uwin_vld_q[k] && (uwin_idx_q[k] == pe.index_left))
            p_leftwin = fx_mul(uwin_val_q[k], pe.i_left);
      end
   end

   // Saturating accumulate, tile completion and result formatting.
   always_comb begin
      sum = SUM_W'(acc_q) + SUM_W'(p_direct) + SUM_W'(p_upwin) + SUM_W'(p_leftwin);
      acc_sat_d = acc_sat_q | (sum > ACC_MAX);
      acc_d     = acc_sat_d ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
      acc_ext   = SUM_W'(acc_d);
      done_up_d   = done_up_q | (up_acc & pe.last_up);
      done_left_d = done_left_q | (left_acc & pe.last_left);
      complete    = done_up_d & done_left_d;
      res_d       = (acc_ext > RES_MAX) ? {DATA_WIDTH{1'b1}} : acc_d[DATA_WIDTH-1:0];
      res_sat_d   = acc_sat_d | (acc_ext > RES_MAX);
      busy_d      = (busy_q | up_acc | left_acc) & ~complete;
   end

   // Pass-through registers: operands travel on regardless of compute state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_dn_q <= '0; fwd_dn_idx_q <= '0; fwd_dn_vld_q <= 1'b0; fwd_dn_last_q <= 1'b0;
         fwd_rt_q <= '0; fwd_rt_idx_q <= '0; fwd_rt_vld_q <= 1'b0; fwd_rt_last_q <= 1'b0;
      end else begin
         fwd_dn_q <= pe.i_up;   fwd_dn_idx_q <= pe.index_up;
         fwd_dn_vld_q <= pe.valid_up; fwd_dn_last_q <= pe.last_up;
         fwd_rt_q <= pe.i_left; fwd_rt_idx_q <= pe.index_left;
         fwd_rt_vld_q <= pe.valid_left; fwd_rt_last_q <= pe.last_left;
      end
   end

   // Tile state: windows, accumulator, done flags; everything clears when a tile completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uwin_idx_q <= '0; uwin_val_q <= '0; uwin_vld_q <= '0;
         lwin_idx_q <= '0; lwin_val_q <= '0; lwin_vld_q <= '0;
         acc_q <= '0; acc_sat_q <= 1'b0;
         done_up_q <= 1'b0; done_left_q <= 1'b0;
      end else if (complete) begin
         uwin_idx_q <= '0; uwin_val_q <= '0; uwin_vld_q <= '0;
         lwin_idx_q <= '0; lwin_val_q <= '0; lwin_vld_q <= '0;
         acc_q <= '0; acc_sat_q <= 1'b0;
         done_up_q <= 1'b0; done_left_q <= 1'b0;
      end else begin
         acc_q <= acc_d; acc_sat_q <= acc_sat_d;
         done_up_q <= done_up_d; done_left_q <= done_left_d;
         if (up_acc) begin
            for (int k = CACHE_DEPTH-1; k > 0; k--) begin
               uwin_idx_q[k] <= uwin_idx_q[k-1];
               uwin_val_q[k] <= uwin_val_q[k-1];
               uwin_vld_q[k] <= uwin_vld_q[k-1];
            end
            uwin_idx_q[0] <= pe.index_up; uwin_val_q[0] <= pe.i_up; uwin_vld_q[0] <= 1'b1;
         end
         if (left_acc) begin
            for (int k = CACHE_DEPTH-1; k > 0; k--) begin
               lwin_idx_q[k] <= lwin_idx_q[k-1];
               lwin_val_q[k] <= lwin_val_q[k-1];
               lwin_vld_q[k] <= lwin_vld_q[k-1];
            end
            lwin_idx_q[0] <= pe.index_left; lwin_val_q[0] <= pe.i_left; lwin_vld_q[0] <= 1'b1;
         end
      end
   end

   // Result registers: strobe for one cycle, value and saturation flag hold until the next tile.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= '0; res_vld_q <= 1'b0; res_sat_q <= 1'b0; busy_q <= 1'b0;
      end else begin
         res_vld_q <= complete;
         busy_q    <= busy_d;
         if (complete) begin
            res_q     <= res_d;
            res_sat_q <= res_sat_d;
         end
      end
   end

   assign pe.o_down         = fwd_dn_q;
   assign pe.index_down     = fwd_dn_idx_q;
   assign pe.valid_down     = fwd_dn_vld_q;
   assign pe.last_down      = fwd_dn_last_q;
   assign pe.o_right        = fwd_rt_q;
   assign pe.index_right    = fwd_rt_idx_q;
   assign pe.valid_right    = fwd_rt_vld_q;
   assign pe.last_right     = fwd_rt_last_q;
   assign pe.o_result       = res_q;
   assign pe.o_result_valid = res_vld_q;
   assign pe.o_sat          = res_sat_q;
   assign pe.busy           = busy_q;
endmodule

// File: tb/tb_sparse_pe_stream.sv
// Directed bench for sparse_pe_stream: table of per-edge vectors plus hand-written corner sequences.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none; stimulus is applied every cycle.
module tb_sparse_pe_stream;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   sparse_pe_stream_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) ifa ();
   sparse_pe_stream_if #(.DATA_WIDTH(8), .INDEX_SIZE(3)) ifb ();

   // The depth-2 instance sees exactly the same stimulus as the depth-4 one.
   assign ifb.i_up       = ifa.i_up;
   assign ifb.i_left     = ifa.i_left;
   assign ifb.index_up   = ifa.index_up;
   assign ifb.index_left = ifa.index_left;
   assign ifb.valid_up   = ifa.valid_up;
   assign ifb.valid_left = ifa.valid_left;
   assign ifb.last_up    = ifa.last_up;
   assign ifb.last_left  = ifa.last_left;

   sparse_pe_stream #(.DATA_WIDTH(8), .FRAC_BITS(4), .INDEX_SIZE(3), .ACC_WIDTH(16),
                      .CACHE_DEPTH(4)) dut_a (.clk(clk), .rst(rst), .pe(ifa.slave));
   sparse_pe_stream #(.DATA_WIDTH(8), .FRAC_BITS(4), .INDEX_SIZE(3), .ACC_WIDTH(16),
                      .CACHE_DEPTH(2)) dut_b (.clk(clk), .rst(rst), .pe(ifb.slave));

   typedef struct {
      logic       vu; logic [2:0] iu; logic [7:0] du; logic lu;
      logic       vl; logic [2:0] il; logic [7:0] dl; logic ll;
      logic       rv; logic [7:0] res; logic sat; logic busy;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(input logic vu, input logic [2:0] iu, input logic [7:0] du,
                               input logic lu, input logic vl, input logic [2:0] il,
                               input logic [7:0] dl, input logic ll, input logic rv,
                               input logic [7:0] res, input logic sat, input logic busy);
      vec_t v;
      v.vu = vu; v.iu = iu; v.du = du; v.lu = lu;
      v.vl = vl; v.il = il; v.dl = dl; v.ll = ll;
      v.rv = rv; v.res = res; v.sat = sat; v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic vu, input logic [2:0] iu, input logic [7:0] du, input logic lu,
                        input logic vl, input logic [2:0] il, input logic [7:0] dl, input logic ll);
      ifa.valid_up = vu;   ifa.index_up = iu;   ifa.i_up = du;   ifa.last_up = lu;
      ifa.valid_left = vl; ifa.index_left = il; ifa.i_left = dl; ifa.last_left = ll;
   endtask

   // One edge: drive at negedge, sample after the rising edge, check the one-cycle pass-through.
   task automatic apply(input logic vu, input logic [2:0] iu, input logic [7:0] du, input logic lu,
                        input logic vl, input logic [2:0] il, input logic [7:0] dl, input logic ll);
      @(negedge clk);
      drive(vu, iu, du, lu, vl, il, dl, ll);
      @(posedge clk);
      #1;
      chk("fwd_down", {ifa.o_down, 1'b0, ifa.index_down, ifa.valid_down, ifa.last_down},
          {du, 1'b0, iu, vu, lu});
      chk("fwd_right", {ifa.o_right, 1'b0, ifa.index_right, ifa.valid_right, ifa.last_right},
          {dl, 1'b0, il, vl, ll});
   endtask

   task automatic chk_res(input string tag, input logic rv, input logic [7:0] res,
                          input logic sat, input logic busy);
      chk({tag, "_rv"},   32'(ifa.o_result_valid), 32'(rv));
      chk({tag, "_res"},  32'(ifa.o_result),       32'(res));
      chk({tag, "_sat"},  32'(ifa.o_sat),          32'(sat));
      chk({tag, "_busy"}, 32'(ifa.busy),           32'(busy));
   endtask

   initial begin
      //          up: v idx  val  L   left: v idx  val  L    exp: rv res sat busy
      tbl[0]  = mk(1, 2, 8'h20, 1,  1, 2, 8'h30, 1,  1, 8'h60, 0, 0); // direct match
      tbl[1]  = mk(0, 0, 8'h00, 0,  0, 0, 8'h00, 0,  0, 8'h60, 0, 0);
      tbl[2]  = mk(1, 1, 8'h20, 0,  1, 3, 8'h30, 0,  0, 8'h60, 0, 1); // cross match
      tbl[3]  = mk(1, 3, 8'h10, 1,  1, 5, 8'h40, 1,  1, 8'h30, 0, 0);
      tbl[4]  = mk(1, 0, 8'hFF, 0,  1, 0, 8'hFF, 0,  0, 8'h30, 0, 1); // saturation
      tbl[5]  = mk(1, 1, 8'hFF, 0,  1, 1, 8'hFF, 0,  0, 8'h30, 0, 1);
      tbl[6]  = mk(1, 2, 8'hFF, 0,  1, 2, 8'hFF, 0,  0, 8'h30, 0, 1);
      tbl[7]  = mk(1, 3, 8'hFF, 1,  1, 3, 8'hFF, 1,  1, 8'hFF, 1, 0);
      tbl[8]  = mk(1, 5, 8'h10, 1,  1, 5, 8'h80, 1,  1, 8'h80, 0, 0); // back-to-back tiles
      tbl[9]  = mk(1, 6, 8'h08, 1,  1, 6, 8'h20, 1,  1, 8'h10, 0, 0);
      tbl[10] = mk(0, 0, 8'h00, 0,  0, 0, 8'h00, 0,  0, 8'h10, 0, 0);
      tbl[11] = mk(1, 2, 8'h10, 1,  1, 1, 8'h10, 0,  0, 8'h10, 0, 1); // up done early
      tbl[12] = mk(1, 2, 8'h40, 0,  1, 2, 8'h30, 1,  1, 8'h30, 0, 0); // late up element ignored
      tbl[13] = mk(0, 2, 8'hFF, 1,  1, 4, 8'h20, 0,  0, 8'h30, 0, 1); // invalid last ignored
      tbl[14] = mk(1, 4, 8'h20, 1,  1, 6, 8'h10, 1,  1, 8'h40, 0, 0);

      drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
      #1;
      chk("reset_rv", 32'(ifa.o_result_valid), 32'd0);
      chk("reset_res", 32'(ifa.o_result), 32'd0);
      chk("reset_busy", 32'(ifa.busy), 32'd0);
      chk("reset_fwd", {ifa.o_down, ifa.valid_down, ifa.o_right, ifa.valid_right}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         apply(tbl[i].vu, tbl[i].iu, tbl[i].du, tbl[i].lu,
               tbl[i].vl, tbl[i].il, tbl[i].dl, tbl[i].ll);
         chk_res($sformatf("vec%0d", i), tbl[i].rv, tbl[i].res, tbl[i].sat, tbl[i].busy);
      end

      // Window limit: up index 4 arrives three up-elements before left index 4.
      apply(1, 4, 8'h20, 0,  1, 1, 8'h11, 0);
      apply(1, 5, 8'h11, 0,  1, 2, 8'h11, 0);
      apply(1, 6, 8'h11, 1,  1, 3, 8'h11, 0);
      chk("win_b_busy", 32'(ifb.busy), 32'd1);
      apply(0, 0, 8'h00, 0,  1, 4, 8'h40, 1);
      chk_res("win_d4", 1, 8'h80, 0, 0);
      chk("win_d2_rv", 32'(ifb.o_result_valid), 32'd1);
      chk("win_d2_res", 32'(ifb.o_result), 32'd0);

      // Reset mid-tile: partial sum must be discarded, no strobe for the aborted tile.
      apply(1, 1, 8'h40, 0,  1, 1, 8'h40, 0);
      apply(1, 2, 8'h10, 0,  1, 3, 8'h10, 0);
      chk("pre_rst_busy", 32'(ifa.busy), 32'd1);
      @(negedge clk);
      drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
      rst = 1'b1;
      #1;
      chk_res("in_rst", 0, 8'h00, 0, 0);
      chk("in_rst_fwd", {ifa.o_down, ifa.valid_down, ifa.o_right, ifa.valid_right}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      apply(0, 0, 8'h00, 0,  0, 0, 8'h00, 0);
      chk_res("post_rst0", 0, 8'h00, 0, 0);
      apply(0, 0, 8'h00, 0,  0, 0, 8'h00, 0);
      chk_res("post_rst1", 0, 8'h00, 0, 0);
      apply(1, 3, 8'h20, 1,  1, 3, 8'h20, 1);
      chk_res("post_rst_tile", 1, 8'h40, 0, 0);
      apply(0, 0, 8'h00, 0,  0, 0, 8'h00, 0);
      chk_res("post_rst_hold", 0, 8'h40, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sparse_pe_stream.md
SPARSE_PE_STREAM -- requirements
Module: sparse_pe_stream

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, operand/result width; FRAC_BITS, default 4, fixed-point fraction bits; INDEX_SIZE, default 3, index width; ACC_WIDTH, default 16, accumulator width (≥ DATA_WIDTH); CACHE_DEPTH, default 4, per-side match window (1..16).
REQ-002 SHALL have ports; one clock; reset asynchronous, active-high:
  clk  in  1  clock, rising-edge
  rst  in  1  asynchronous active-high reset
  i_up, i_left  in  DATA_WIDTH  operand from above / left
  index_up, index_left  in  INDEX_SIZE  operand index
  valid_up, valid_left  in  1  operand qualifier
  last_up, last_left  in  1  final element of the current tile on that side
  o_down, o_right  out  DATA_WIDTH  forwarded operand
  index_down, index_right  out  INDEX_SIZE  forwarded index
  valid_down, valid_right, last_down, last_right  out  1  forwarded flags
  o_result  out  DATA_WIDTH  saturated dot product
  o_result_valid  out  1  one-cycle result strobe
  o_sat  out  1  o_result was clipped, qualified by o_result_valid
  busy  out  1  tile in progress (≥1 valid element accepted, result not yet emitted)

Function
REQ-003 SHALL register all forwarded outputs unconditionally every cycle: 1-cycle latency, independent of compute state.
REQ-004 SHALL treat each side as a stream of (index, value) pairs, strictly ascending in index within a tile; zero values are ordinary data.
REQ-005 SHALL hold per side a shift window of the last CACHE_DEPTH accepted elements; a valid element shifts in, the oldest drops when full.
REQ-006 SHALL, per edge, compare each new valid element against the current new element of the other side and against the other side's window (pre-shift contents only).
REQ-007 SHALL count a direct match (index_up == index_left, both valid) exactly once; the up-vs-left-window and left-vs-up-window matches are each added separately: at most 2 products per edge.
REQ-008 SHALL compute each product as (a*b) >> FRAC_BITS, unsigned, truncated, full 2*DATA_WIDTH precision before the shift.
REQ-009 SHALL add products into an ACC_WIDTH unsigned accumulator that saturates at 2^ACC_WIDTH-1 (sticky until tile end).
REQ-010 SHALL set a per-side done flag on a valid element with last=1; a side that is done accepts no further elements into its window or compare for that tile. Those elements are still forwarded.
REQ-011 SHALL, on the edge where both sides are done (including the edge that samples the completing last, that edge's products included), register o_result = min(acc, 2^DATA_WIDTH-1), o_sat = (acc > 2^DATA_WIDTH-1 or accumulator saturated), o_result_valid = 1.
REQ-012 SHALL on that same edge clear the accumulator, both windows and done flags; inputs on the following edge start a new tile.
REQ-013 SHALL hold o_result_valid high for exactly one cycle; o_result and o_sat hold value until the next result.
REQ-014 SHALL miss (not accumulate) matches whose arrival distance exceeds CACHE_DEPTH; with CACHE_DEPTH ≥ 2^INDEX_SIZE the dot product is exact.
REQ-015 SHALL treat valid=0 inputs as absent (no window shift, no compare, last ignored).

Reset
REQ-016 SHALL, while rst=1, asynchronously clear all outputs, accumulator, windows and done flags to 0.
REQ-017 SHALL, on rst mid-tile, discard partial state; no o_result_valid is emitted for the aborted tile.

Verification
REQ-018 Direct match: both sides (idx2,0x20)/(idx2,0x30) with last=1 -> o_result_valid next cycle, o_result=0x60, o_sat=0.
REQ-019 Cross match: up (1,0x20),(3,0x10,last); left (3,0x30),(5,0x40,last) -> o_result=0x30 (single count).
REQ-020 Saturation: 4 direct pairs 0xFF*0xFF -> acc=0x3F80, o_result=0xFF, o_sat=1.
REQ-021 Window limit: CACHE_DEPTH=2, matching index 3 positions apart -> o_result=0x00; CACHE_DEPTH=4 -> correct product.
REQ-022 Back-to-back tiles: second tile starts the edge after completion -> second result excludes first tile's sum.
REQ-023 Reset mid-tile and pass-through: rst pulse after 2 elements -> busy=0, no strobe. Forwarded outputs equal inputs delayed 1 cycle throughout.
